decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width; only 32 is supported.
REQ-002 Parameter NOP_INSTR, 32'h00000013, instruction word used for bubbles.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 instr  in  32  instruction word from the IF_ID register.
REQ-006 PC_n  in  32  PC+4 of instr, from the IF_ID register.
REQ-007 flush  in  1  squash the instruction entering EX (taken branch/jump).
REQ-008 wb_en, wb_rd[4:0], wb_data[31:0]  in  write-back port to the register file.
REQ-009 stall  out  1  combinational; holds PC and IF_ID when high.
REQ-010 ex_valid, ex_pc[31:0], ex_pc4[31:0]  out  ID/EX valid flag, PC, PC+4.
REQ-011 ex_rs1_data, ex_rs2_data, ex_imm  out  32 each  operands and sign-extended immediate.
REQ-012 ex_rs1, ex_rs2, ex_rd  out  5 each  register indices for forwarding and write-back.
REQ-013 ex_alu_op[3:0], ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump  out  control bundle.

Function
REQ-014 Decode SHALL support R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC (RV32I base).
REQ-015 Immediates SHALL follow RV32I I/S/B/U/J formats, sign-extended from instr[31].
REQ-016 ex_pc SHALL be PC_n minus 4, modulo 2^32; ex_pc4 SHALL be PC_n.
REQ-017 The ID/EX register SHALL capture decoded fields on every rising clk edge: latency exactly one cycle.
REQ-018 Load-use hazard: stall SHALL be 1 when ex_valid and ex_mem_read and ex_rd!=0 and ex_rd equals a source register the current instr actually reads.
REQ-019 While stall is 1, the ID/EX register SHALL load a bubble: ex_valid=0 and all control outputs 0.
REQ-020 When flush is 1, a bubble SHALL be loaded; flush has priority over stall, and stall SHALL be forced to 0.
REQ-021 Unsupported opcodes SHALL load a bubble without asserting stall.
REQ-022 The register file SHALL have 32x32 entries; x0 SHALL read 0, and writes to x0 SHALL be ignored.
REQ-023 A register-file write SHALL occur on a rising clk edge when wb_en=1; the write is visible to reads in the following cycle, unless REQ-028 applies.
REQ-024 A bubble SHALL report rd=0, rs1=0, rs2=0 so that it never triggers hazards or forwarding.

Reset
REQ-025 On reset, all ID/EX outputs SHALL be 0 and stall SHALL be 0.
REQ-026 Reset asserted mid-stall SHALL clear the pending hazard; the first edge after release decodes the presented instr normally.
REQ-027 Register file contents SHALL be cleared to 0 on reset.

Configuration
REQ-028 With DECODE_BYPASS_EN defined, a read of rsN SHALL return wb_data in the same cycle when wb_en=1, wb_rd=rsN and wb_rd!=0; without the macro, the register file SHALL return the old value and the external forwarding path SHALL cover the case.

Structure
REQ-029 A shared package riscv_pkg SHALL hold the opcode constants, immediate-format enum, ALU-op encodings and the NOP constant.
REQ-030 The register file SHALL be a separate sub-module, regfile, instantiated once; decode, hazard logic and ID/EX register SHALL stay in decode_stage.

Verification
REQ-031 Reset: assert reset mid-cycle -> all outputs are 0 immediately (asynchronous); after release, instr=NOP_INSTR, PC_n=4 -> next edge ex_valid=1, ex_pc=0, ex_pc4=4.
REQ-032 ALU decode: wb writes x1=5; then instr addi x2,x1,-3 (32'hFFD08113) -> ex_rs1_data=5, ex_imm=32'hFFFFFFFD, ex_rd=2, ex_alu_src=1, ex_reg_write=1.
REQ-033 Load-use: lw x3,0(x1) followed by add x4,x3,x1 -> stall=1 for exactly one cycle, one bubble in EX, then the add issues with ex_rs1=3.
REQ-034 Flush priority: flush=1 while a load-use stall condition holds -> stall=0, ex_valid=0 on the next edge.
REQ-035 x0 and bypass: wb_en=1 with wb_rd=0 and wb_data=32'hDEAD -> reads of x0 return 0; wb_rd=5 in the same cycle as decoding rs1=5 -> ex_rs1_data=wb_data only when DECODE_BYPASS_EN is defined.
REQ-036 Immediates: beq with offset -8, jal with offset +2048, lui 0x12345 -> ex_imm values 32'hFFFFFFF8, 32'h00000800, 32'h12345000.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I decode stage: opcode constants, the
// immediate-format enum, ALU-op encodings, the canonical NOP word, the ID/EX
// bundle type and two small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

  // Canonical RV32I no-op: addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // ALU_LUI passes operand B through; ALU_AUIPC tells EX to add B to the PC.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;

  // ID/EX register contents
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
  } idex_t;

  // Sign-extended immediate for the given RV32I format
  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'd0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // funct3/funct7 to ALU op; SUB exists only for register-register ops,
  // while instr[30] selects SRA/SRAI for both forms.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic bit30,
                                         input logic is_reg);
    alu_op_e op;
    case (funct3)
      3'd0:    op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = bit30 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// 32 x 32-bit register file, two combinational read ports, one write port.
// x0 always reads 0 and ignores writes. Contents clear on reset.
// Optional macro DECODE_BYPASS_EN: a read of the register being written in
// the same cycle returns the write data instead of the stored value.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   i_rs1_addr/i_rs2_addr  read addresses
//   o_rs1_data/o_rs2_data  read data
//   i_we, i_wr_addr, i_wr_data  write port (takes effect on rising clk)
// -----------------------------------------------------------------------------
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_we,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data
);

  logic [31:0] r_mem [32];
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;

  // Storage: clear on reset, write on rising edge except to x0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        r_mem[k] <= 32'd0;
      end
    end else if (i_we && (i_wr_addr != 5'd0)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port 1
  always_comb begin
    if (i_rs1_addr == 5'd0) begin
      w_rs1_data = 32'd0;
    end
`ifdef DECODE_BYPASS_EN
    else if (i_we && (i_wr_addr == i_rs1_addr)) begin
      w_rs1_data = i_wr_data;
    end
`endif
    else begin
      w_rs1_data = r_mem[i_rs1_addr];
    end
  end

  // Read port 2
  always_comb begin
    if (i_rs2_addr == 5'd0) begin
      w_rs2_data = 32'd0;
    end
`ifdef DECODE_BYPASS_EN
    else if (i_we && (i_wr_addr == i_rs2_addr)) begin
      w_rs2_data = i_wr_data;
    end
`endif
    else begin
      w_rs2_data = r_mem[i_rs2_addr];
    end
  end

  assign o_rs1_data = w_rs1_data;
  assign o_rs2_data = w_rs2_data;

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// RV32I instruction decode: control/immediate generation, register-file read,
// load-use hazard detection and the ID/EX pipeline register.
// Optional macro DECODE_BYPASS_EN (passed into regfile): same-cycle write-back
// bypass on register reads.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   instr, PC_n                  instruction and its PC+4 from IF_ID
//   flush                        squash the instruction entering EX
//   wb_en, wb_rd, wb_data        register-file write-back port
//   stall                        combinational load-use stall (hold PC/IF_ID)
//   ex_*                         ID/EX register outputs
// -----------------------------------------------------------------------------
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] PC_n,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            ex_jump
);

  idex_t    r_idex;
  idex_t    w_next;

  logic     w_supported;
  logic     w_use_rs1;
  logic     w_use_rs2;
  logic     w_has_rd;
  imm_fmt_e w_fmt;
  alu_op_e  w_alu_op;
  logic     w_alu_src;
  logic     w_mem_read;
  logic     w_mem_write;
  logic     w_mem_to_reg;
  logic     w_branch;
  logic     w_jump;

  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_load_use;
  logic        w_bubble;

  // Opcode classification and control bundle
  always_comb begin
    w_supported  = 1'b1;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    w_has_rd     = 1'b0;
    w_fmt        = IMM_NONE;
    w_alu_op     = ALU_ADD;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_has_rd  = 1'b1;
        w_alu_op  = alu_decode(instr[14:12], instr[30], 1'b1);
      end
      OPC_OP_IMM: begin
        w_use_rs1 = 1'b1;
        w_has_rd  = 1'b1;
        w_fmt     = IMM_I;
        w_alu_src = 1'b1;
        w_alu_op  = alu_decode(instr[14:12], instr[30], 1'b0);
      end
      OPC_LOAD: begin
        w_use_rs1    = 1'b1;
        w_has_rd     = 1'b1;
        w_fmt        = IMM_I;
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_fmt       = IMM_S;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_fmt     = IMM_B;
        w_alu_op  = ALU_SUB;
        w_branch  = 1'b1;
      end
      OPC_JAL: begin
        w_has_rd = 1'b1;
        w_fmt    = IMM_J;
        w_jump   = 1'b1;
      end
      OPC_JALR: begin
        w_use_rs1 = 1'b1;
        w_has_rd  = 1'b1;
        w_fmt     = IMM_I;
        w_alu_src = 1'b1;
        w_jump    = 1'b1;
      end
      OPC_LUI: begin
        w_has_rd  = 1'b1;
        w_fmt     = IMM_U;
        w_alu_src = 1'b1;
        w_alu_op  = ALU_LUI;
      end
      OPC_AUIPC: begin
        w_has_rd  = 1'b1;
        w_fmt     = IMM_U;
        w_alu_src = 1'b1;
        w_alu_op  = ALU_AUIPC;
      end
      default: begin
        w_supported = 1'b0;
      end
    endcase
  end

  // Only registers the instruction really reads get a non-zero index, so
  // immediate fields that alias rs1/rs2 never fake a hazard or a forward.
  assign w_rs1_idx = w_use_rs1 ? instr[19:15] : 5'd0;
  assign w_rs2_idx = w_use_rs2 ? instr[24:20] : 5'd0;

  regfile u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (w_rs1_idx),
    .i_rs2_addr (w_rs2_idx),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (wb_en),
    .i_wr_addr  (wb_rd),
    .i_wr_data  (wb_data)
  );

  // Load in EX whose result the current instruction needs; bubbles carry
  // rd=0 so they never match.
  assign w_load_use = r_idex.valid & r_idex.mem_read & (r_idex.rd != 5'd0) &
                      ((r_idex.rd == w_rs1_idx) | (r_idex.rd == w_rs2_idx));
  assign stall      = w_load_use & ~flush;
  assign w_bubble   = flush | w_load_use | ~w_supported;

  // Next ID/EX contents: decoded instruction or a bubble
  always_comb begin
    w_next = '0;
    if (w_bubble) begin
      // Bubble: invalid, all controls/indices zero; immediate is the NOP's
      w_next.imm = gen_imm(NOP_INSTR, IMM_I);
    end else begin
      w_next.valid      = 1'b1;
      w_next.pc         = PC_n - 32'd4;
      w_next.pc4        = PC_n;
      w_next.rs1_data   = w_rs1_data;
      w_next.rs2_data   = w_rs2_data;
      w_next.imm        = gen_imm(instr, w_fmt);
      w_next.rs1        = w_rs1_idx;
      w_next.rs2        = w_rs2_idx;
      w_next.rd         = w_has_rd ? instr[11:7] : 5'd0;
      w_next.alu_op     = w_alu_op;
      w_next.alu_src    = w_alu_src;
      w_next.mem_read   = w_mem_read;
      w_next.mem_write  = w_mem_write;
      w_next.reg_write  = w_has_rd;
      w_next.mem_to_reg = w_mem_to_reg;
      w_next.branch     = w_branch;
      w_next.jump       = w_jump;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_next;
    end
  end

  assign ex_valid      = r_idex.valid;
  assign ex_pc         = r_idex.pc;
  assign ex_pc4        = r_idex.pc4;
  assign ex_rs1_data   = r_idex.rs1_data;
  assign ex_rs2_data   = r_idex.rs2_data;
  assign ex_imm        = r_idex.imm;
  assign ex_rs1        = r_idex.rs1;
  assign ex_rs2        = r_idex.rs2;
  assign ex_rd         = r_idex.rd;
  assign ex_alu_op     = r_idex.alu_op;
  assign ex_alu_src    = r_idex.alu_src;
  assign ex_mem_read   = r_idex.mem_read;
  assign ex_mem_write  = r_idex.mem_write;
  assign ex_reg_write  = r_idex.reg_write;
  assign ex_mem_to_reg = r_idex.mem_to_reg;
  assign ex_branch     = r_idex.branch;
  assign ex_jump       = r_idex.jump;

endmodule
